// File: rtl/uart_receive_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/odd/even parity, 1 or 2 stop bits.
// Each bit is decided by a 3-sample majority vote around mid-bit; flags accompany every byte.
module uart_receive_cfg #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 9600,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic                 dout_valid,
    output logic [DATA_BITS-1:0] dout,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int CPB  = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);

    if (CPB < 4) begin : g_chk_cpb
        $error("uart_receive_cfg: clocks per bit must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_receive_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_par
        $error("uart_receive_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("uart_receive_cfg: STOP_BITS must be 1 or 2");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("uart_receive_cfg: SYNC_STAGES must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_DONE      = 3'd5,
        S_WAIT_HIGH = 3'd6
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_bad(input logic [DATA_BITS-1:0] data, input logic p);
        logic x;
        x = (^data) ^ p;
        if (PARITY == 1) begin
            return ~x;
        end else if (PARITY == 2) begin
            return x;
        end else begin
            return 1'b0;
        end
    endfunction

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   par_q, par_d;
    logic                   ferr_q, ferr_d;
    logic                   v0_q, v0_d, v1_q, v1_d;
    logic                   valid_q, valid_d;
    logic [DATA_BITS-1:0]   dout_q, dout_d;
    logic                   perr_q, perr_d;
    logic                   fe_q, fe_d;
    logic                   brk_q, brk_d;
    logic                   busy_q, busy_d;

    logic s_s, voted_s, at_m1_s, at_mid_s, at_vote_s, at_end_s, done_entry_s;

    assign s_s       = sync_q[SYNC_STAGES-1];
    assign at_m1_s   = (cnt_q == CW'(HALF - 1));
    assign at_mid_s  = (cnt_q == CW'(HALF));
    assign at_vote_s = (cnt_q == CW'(HALF + 1));
    assign at_end_s  = (cnt_q == CW'(CPB - 1));
    assign voted_s   = majority3(v0_q, v1_q, s_s);

    // State, datapath and output registers; reset parks the line synchroniser at idle-high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sync_q  <= {SYNC_STAGES{1'b1}};
            cnt_q   <= {CW{1'b0}};
            bit_q   <= 4'd0;
            data_q  <= {DATA_BITS{1'b0}};
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
            v0_q    <= 1'b1;
            v1_q    <= 1'b1;
            valid_q <= 1'b0;
            dout_q  <= {DATA_BITS{1'b0}};
            perr_q  <= 1'b0;
            fe_q    <= 1'b0;
            brk_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            par_q   <= par_d;
            ferr_q  <= ferr_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
            perr_q  <= perr_d;
            fe_q    <= fe_d;
            brk_q   <= brk_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        data_d  = data_q;
        par_d   = par_q;
        ferr_d  = ferr_q;
        v0_d    = at_m1_s  ? s_s : v0_q;
        v1_d    = at_mid_s ? s_s : v1_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = {CW{1'b0}};
                if (!s_s) begin
                    state_d = S_START;
                    ferr_d  = 1'b0;
                    par_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (at_vote_s && voted_s) begin
                    state_d = S_IDLE;
                end else if (at_end_s) begin
                    state_d = S_DATA;
                    cnt_d   = {CW{1'b0}};
                    bit_d   = 4'd0;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (at_vote_s) begin
                    data_d = {voted_s, data_q[DATA_BITS-1:1]};
                end else begin
                    data_d = data_q;
                end
                if (at_end_s) begin
                    cnt_d = {CW{1'b0}};
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d   = 4'd0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (at_vote_s) begin
                    par_d = voted_s;
                end else begin
                    par_d = par_q;
                end
                if (at_end_s) begin
                    state_d = S_STOP;
                    cnt_d   = {CW{1'b0}};
                    bit_d   = 4'd0;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (at_vote_s) begin
                    ferr_d = ferr_q | ~voted_s;
                end else begin
                    ferr_d = ferr_q;
                end
                // The last stop bit completes at its vote so back-to-back start edges are never missed
                if (at_vote_s && (bit_q == 4'(STOP_BITS - 1))) begin
                    state_d = S_DONE;
                end else if (at_end_s) begin
                    cnt_d = {CW{1'b0}};
                    bit_d = bit_q + 4'd1;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_DONE: begin
                cnt_d   = {CW{1'b0}};
                state_d = s_s ? S_IDLE : S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                cnt_d = {CW{1'b0}};
                if (s_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_HIGH;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Output register inputs: byte and flags are loaded on the edge that enters DONE
    always_comb begin
        done_entry_s = (state_q == S_STOP) && (state_d == S_DONE);
        valid_d      = done_entry_s;
        busy_d       = (state_d != S_IDLE);
        if (done_entry_s) begin
            dout_d = data_q;
            perr_d = parity_bad(data_q, par_q);
            fe_d   = ferr_d;
            brk_d  = ferr_d && (data_q == {DATA_BITS{1'b0}}) && !par_q;
        end else begin
            dout_d = dout_q;
            perr_d = 1'b0;
            fe_d   = 1'b0;
            brk_d  = 1'b0;
        end
    end

    assign dout_valid = valid_q;
    assign dout       = dout_q;
    assign parity_err = perr_q;
    assign frame_err  = fe_q;
    assign break_det  = brk_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_receive_cfg.sv
// Directed bench for uart_receive_cfg: three instances (8N1, 8E1, 7O2) at 10 clocks per bit.
module tb_uart_receive_cfg;

    localparam int CPB  = 10;
    localparam int HALF = CPB / 2;
    localparam int SYNC = 2;

    typedef struct {
        int d;
        int pe;
        int fe;
        int bk;
        int cyc;
    } rx_t;

    typedef struct {
        int sel;
        int data;
        int pbit;
        int stops;
        int exp_d;
        int exp_pe;
        int exp_fe;
        int exp_bk;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din0 = 1'b1, din1 = 1'b1, din2 = 1'b1;
    logic dv0, dv1, dv2;
    logic [7:0] dout0, dout1;
    logic [6:0] dout2;
    logic pe0, pe1, pe2, fe0, fe1, fe2, bk0, bk1, bk2, busy0, busy1, busy2;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int consec = 0;
    logic dv0_prev = 1'b0, dv1_prev = 1'b0, dv2_prev = 1'b0;
    rx_t q0[$], q1[$], q2[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    uart_receive_cfg #(.INPUT_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                       .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(SYNC)) u_8n1 (
        .clk(clk), .rst(rst), .din(din0), .dout_valid(dv0), .dout(dout0),
        .parity_err(pe0), .frame_err(fe0), .break_det(bk0), .busy(busy0));

    uart_receive_cfg #(.INPUT_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                       .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(SYNC)) u_8e1 (
        .clk(clk), .rst(rst), .din(din1), .dout_valid(dv1), .dout(dout1),
        .parity_err(pe1), .frame_err(fe1), .break_det(bk1), .busy(busy1));

    uart_receive_cfg #(.INPUT_CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                       .PARITY(1), .STOP_BITS(2), .SYNC_STAGES(SYNC)) u_7o2 (
        .clk(clk), .rst(rst), .din(din2), .dout_valid(dv2), .dout(dout2),
        .parity_err(pe2), .frame_err(fe2), .break_det(bk2), .busy(busy2));

    // Cycle counter used for latency measurement
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Capture every delivered frame and count back-to-back valid pulses
    always @(negedge clk) begin
        if (dv0) q0.push_back('{int'(dout0), int'(pe0), int'(fe0), int'(bk0), cyc});
        if (dv1) q1.push_back('{int'(dout1), int'(pe1), int'(fe1), int'(bk1), cyc});
        if (dv2) q2.push_back('{int'(dout2), int'(pe2), int'(fe2), int'(bk2), cyc});
        if ((dv0 && dv0_prev) || (dv1 && dv1_prev) || (dv2 && dv2_prev)) consec <= consec + 1;
        dv0_prev <= dv0;
        dv1_prev <= dv1;
        dv2_prev <= dv2;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_din(input int sel, input logic v);
        case (sel)
            0:       din0 = v;
            1:       din1 = v;
            default: din2 = v;
        endcase
    endtask

    task automatic pop_rx(input int sel, output rx_t r, output int n);
        r = '{0, 0, 0, 0, 0};
        case (sel)
            0:       begin n = q0.size(); if (n > 0) r = q0.pop_front(); end
            1:       begin n = q1.size(); if (n > 0) r = q1.pop_front(); end
            default: begin n = q2.size(); if (n > 0) r = q2.pop_front(); end
        endcase
    endtask

    // Frame geometry per instance: data bits, parity present, stop bits
    function automatic int nbits_of(input int sel);
        return (sel == 2) ? 7 : 8;
    endfunction
    function automatic int npar_of(input int sel);
        return (sel == 0) ? 0 : 1;
    endfunction
    function automatic int nstop_of(input int sel);
        return (sel == 2) ? 2 : 1;
    endfunction

    // Drive one frame; glitch_idx inverts a single cycle at mid-bit of that frame bit
    task automatic send_frame(input int sel, input int data, input int pbit, input int stops,
                              input int glitch_idx, input int gap);
        logic [12:0] bits;
        int n;
        int k;
        logic v;
        bits = 13'd0;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nbits_of(sel); i++) begin
            bits[n] = 1'(data >> i); n++;
        end
        if (npar_of(sel) != 0) begin
            bits[n] = 1'(pbit); n++;
        end
        for (int i = 0; i < nstop_of(sel); i++) begin
            bits[n] = 1'(stops >> i); n++;
        end
        for (k = 0; k < n; k++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (k == 0 && c == 0) fall_cyc = cyc;
                v = bits[k];
                if (k == glitch_idx && c == HALF + 1) v = ~v;
                set_din(sel, v);
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            set_din(sel, 1'b1);
        end
    endtask

    task automatic check_rx(input string tag, input int sel, input int exp_n, input int exp_d,
                            input int exp_pe, input int exp_fe, input int exp_bk);
        rx_t r;
        int n;
        pop_rx(sel, r, n);
        chk({tag, ".pulses"}, n, exp_n);
        chk({tag, ".dout"}, r.d, exp_d);
        chk({tag, ".parity_err"}, r.pe, exp_pe);
        chk({tag, ".frame_err"}, r.fe, exp_fe);
        chk({tag, ".break_det"}, r.bk, exp_bk);
    endtask

    initial begin
        rx_t r;
        int n;
        int lat;
        int exp_lat;

        //          sel data    p  stops dout   pe fe bk
        vecs[0] = '{0, 'hA5, 0, 1, 'hA5, 0, 0, 0};
        vecs[1] = '{0, 'h00, 0, 1, 'h00, 0, 0, 0};
        vecs[2] = '{0, 'hFF, 0, 0, 'hFF, 0, 1, 0};
        vecs[3] = '{1, 'h07, 0, 1, 'h07, 1, 0, 0};
        vecs[4] = '{1, 'h07, 1, 1, 'h07, 0, 0, 0};
        vecs[5] = '{1, 'h00, 0, 0, 'h00, 0, 1, 1};
        vecs[6] = '{1, 'h00, 1, 0, 'h00, 1, 1, 0};
        vecs[7] = '{2, 'h41, 1, 3, 'h41, 0, 0, 0};
        vecs[8] = '{2, 'h7F, 0, 1, 'h7F, 0, 1, 0};
        vecs[9] = '{2, 'h41, 1, 2, 'h41, 0, 1, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.dout_valid", int'(dv0), 0);
        chk("rst.dout", int'(dout0), 0);
        chk("rst.flags", int'({pe0, fe0, bk0}), 0);
        chk("rst.busy", int'(busy0), 0);
        chk("rst.busy_7o2", int'(busy2), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Table of single frames, each followed by an idle gap
        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].pbit, vecs[i].stops, -1, 25);
            pop_rx(vecs[i].sel, r, n);
            chk($sformatf("vec%0d.pulses", i), n, 1);
            chk($sformatf("vec%0d.dout", i), r.d, vecs[i].exp_d);
            chk($sformatf("vec%0d.parity_err", i), r.pe, vecs[i].exp_pe);
            chk($sformatf("vec%0d.frame_err", i), r.fe, vecs[i].exp_fe);
            chk($sformatf("vec%0d.break_det", i), r.bk, vecs[i].exp_bk);
            lat = r.cyc - fall_cyc;
            exp_lat = SYNC + CPB * (nbits_of(vecs[i].sel) + npar_of(vecs[i].sel)
                      + nstop_of(vecs[i].sel)) + HALF + 2;
            chk($sformatf("vec%0d.latency_ok(lat=%0d)", i, lat),
                int'(lat >= exp_lat - 1 && lat <= exp_lat + 1), 1);
        end

        // 7O2 back-to-back: 0x41 clean, then 0x7F with its second stop bit low
        send_frame(2, 'h41, 1, 3, -1, 0);
        send_frame(2, 'h7F, 0, 1, -1, 25);
        check_rx("b2b.first", 2, 2, 'h41, 0, 0, 0);
        check_rx("b2b.second", 2, 1, 'h7F, 0, 1, 0);

        // Three-cycle low glitch must not start a frame
        @(negedge clk);
        din0 = 1'b0;
        repeat (3) @(negedge clk);
        din0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch.busy_high", int'(busy0), 1);
        repeat (CPB - 3) @(negedge clk);
        chk("glitch.busy_low", int'(busy0), 0);
        repeat (30) @(negedge clk);
        pop_rx(0, r, n);
        chk("glitch.pulses", n, 0);

        // Break: line held low for 40 bit times, then a normal frame
        @(negedge clk);
        din0 = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        chk("break.busy_held", int'(busy0), 1);
        din0 = 1'b1;
        repeat (30) @(negedge clk);
        chk("break.busy_after", int'(busy0), 0);
        check_rx("break", 0, 1, 'h00, 0, 1, 1);
        send_frame(0, 'h3C, 0, 1, -1, 25);
        check_rx("after_break", 0, 1, 'h3C, 0, 0, 0);

        // Single-cycle high glitch at mid-bit of data bit 3 is voted out
        send_frame(0, 'h00, 0, 1, 4, 25);
        check_rx("midbit_glitch", 0, 1, 'h00, 0, 0, 0);

        // Asynchronous reset in the middle of a frame
        send_frame(0, 'h5A, 0, 1, -1, 25);
        check_rx("pre_reset", 0, 1, 'h5A, 0, 0, 0);
        for (int c = 0; c < 4 * CPB + 3; c++) begin
            @(negedge clk);
            din0 = (c < CPB) ? 1'b0 : 1'b1;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("midrst.dout", int'(dout0), 0);
        chk("midrst.dout_valid", int'(dv0), 0);
        chk("midrst.busy", int'(busy0), 0);
        chk("midrst.flags", int'({pe0, fe0, bk0}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8 * CPB) @(negedge clk);
        pop_rx(0, r, n);
        chk("midrst.pulses", n, 0);
        chk("midrst.busy_after", int'(busy0), 0);

        chk("no_consecutive_valid", consec, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
